// File: rtl/ip_rx_arbiter.sv
// ip_rx_arbiter: shares one IP_decoder between two receive word sources.
// Picks a source, pulses the decoder reset, streams the packet with start
// framing, waits for fin/ok and dispatches to UDP/TCP or drops it.
//
// Ports:
//   clk, reset           clock (rising edge), async active-low reset
//   srcN_req/len/data    pending packet, length in words, show-ahead head word
//   srcN_rd              pop strobe (registered)
//   dec_reset/start/data decoder controls and word (registered)
//   dec_protocol/ok/fin  decoder results
//   grant, busy          one-hot owner (00 idle), non-idle flag
//   udp_go/tcp_go/drop   one-cycle dispatch pulses; timeout_err with drop
//   pkt_cnt, drop_cnt    wrapping accepted/dropped counters
//
// Build option: define IP_ARB_RR_EN for round-robin arbitration; otherwise
// src0 has fixed priority over src1.
module ip_rx_arbiter #(
  parameter logic [15:0] MAX_WORDS   = 16'd375,
  parameter int unsigned FIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        src0_req,
  input  logic [15:0] src0_len,
  input  logic [31:0] src0_data,
  output logic        src0_rd,
  input  logic        src1_req,
  input  logic [15:0] src1_len,
  input  logic [31:0] src1_data,
  output logic        src1_rd,
  output logic        dec_reset,
  output logic        dec_start,
  output logic [31:0] dec_data,
  input  logic [7:0]  dec_protocol,
  input  logic        dec_ok,
  input  logic        dec_fin,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        udp_go,
  output logic        tcp_go,
  output logic        drop,
  output logic        timeout_err,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [LEN_W-1:0] MIN_WORDS = 16'd7;
  localparam logic [7:0]       PROTO_UDP = 8'd17;
  localparam logic [7:0]       PROTO_TCP = 8'd6;
  localparam logic [LEN_W-1:0] TMR_LAST  = LEN_W'(FIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CLR, STREAM, DRAIN, WAIT_FIN, DONE
  } state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                dec_reset_q, dec_reset_d;
  logic                dec_start_q, dec_start_d;
  logic [DATA_W-1:0]   dec_data_q, dec_data_d;
  logic                rd0_q, rd0_d;
  logic                rd1_q, rd1_d;
  logic                udp_q, udp_d;
  logic                tcp_q, tcp_d;
  logic                drop_q, drop_d;
  logic                tmo_q, tmo_d;
  logic [LEN_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                win_c;
  logic [LEN_W-1:0]    win_len_c;
  logic                len_ok_c;
  logic                last_pop_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                pops_c;

  // Arbitration: only consulted in IDLE when at least one source requests.
`ifdef IP_ARB_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    win_c = (src0_req && src1_req) ? rr_q : src1_req;
  end

  // Pointer moves past the source just served.
  always_comb begin
    rr_d = rr_q;
    if (state_q == DONE) rr_d = ~sel_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  always_comb begin
    win_c = ~src0_req;
  end
`endif

  always_comb begin
    win_len_c  = win_c ? src1_len : src0_len;
    len_ok_c   = (win_len_c >= MIN_WORDS) && (win_len_c <= MAX_WORDS);
    sel_data_c = sel_q ? src1_data : src0_data;
    last_pop_c = (cnt_q == LEN_W'(len_q - 16'd1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    grant_d     = grant_q;
    dec_start_d = 1'b0;
    dec_data_d  = dec_data_q;
    udp_d       = 1'b0;
    tcp_d       = 1'b0;
    drop_d      = 1'b0;
    tmo_d       = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (src0_req || src1_req) begin
          sel_d   = win_c;
          len_d   = win_len_c;
          cnt_d   = '0;
          grant_d = win_c ? 2'b10 : 2'b01;
          state_d = len_ok_c ? CLR : DRAIN;
        end
      end
      CLR: state_d = STREAM;
      STREAM: begin
        // The word popped this cycle is presented to the decoder next cycle;
        // the final two words carry no start framing.
        dec_data_d  = sel_data_c;
        dec_start_d = (cnt_q < LEN_W'(len_q - 16'd2));
        cnt_d       = cnt_q + 16'd1;
        if (last_pop_c) begin
          tmr_d   = '0;
          state_d = WAIT_FIN;
        end
      end
      DRAIN: begin
        // A zero-length request has nothing to pop and drops at once.
        if ((len_q == '0) || last_pop_c) begin
          drop_d     = 1'b1;
          drop_cnt_d = drop_cnt_q + 16'd1;
          grant_d    = 2'b00;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_FIN: begin
        // fin takes precedence over an expiring timer in the same cycle.
        if (dec_fin) begin
          grant_d = 2'b00;
          state_d = DONE;
          if (dec_ok && (dec_protocol == PROTO_UDP)) begin
            udp_d     = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else if (dec_ok && (dec_protocol == PROTO_TCP)) begin
            tcp_d     = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            drop_d     = 1'b1;
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else if (tmr_q == TMR_LAST) begin
          drop_d     = 1'b1;
          tmo_d      = 1'b1;
          drop_cnt_d = drop_cnt_q + 16'd1;
          grant_d    = 2'b00;
          state_d    = DONE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Level outputs follow the state being entered so they align with it.
    pops_c      = (state_d == STREAM) || ((state_d == DRAIN) && (len_d != '0));
    rd0_d       = pops_c && !sel_d;
    rd1_d       = pops_c && sel_d;
    dec_reset_d = (state_d == CLR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      dec_reset_q <= 1'b1;
      dec_start_q <= 1'b0;
      dec_data_q  <= '0;
      rd0_q       <= 1'b0;
      rd1_q       <= 1'b0;
      udp_q       <= 1'b0;
      tcp_q       <= 1'b0;
      drop_q      <= 1'b0;
      tmo_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      dec_reset_q <= dec_reset_d;
      dec_start_q <= dec_start_d;
      dec_data_q  <= dec_data_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      udp_q       <= udp_d;
      tcp_q       <= tcp_d;
      drop_q      <= drop_d;
      tmo_q       <= tmo_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign src0_rd     = rd0_q;
  assign src1_rd     = rd1_q;
  assign dec_reset   = dec_reset_q;
  assign dec_start   = dec_start_q;
  assign dec_data    = dec_data_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign udp_go      = udp_q;
  assign tcp_go      = tcp_q;
  assign drop        = drop_q;
  assign timeout_err = tmo_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_ip_rx_arbiter.sv
// Bench for ip_rx_arbiter: two source FIFO models, a decoder responder and a
// scoreboard of expected packets/words/grant order checked at dispatch.
`timescale 1ns/1ps
module tb_ip_rx_arbiter;

  localparam int FIN_TO  = 16;
  localparam int MAXW    = 375;
  localparam int K_UDP   = 0;
  localparam int K_TCP   = 1;
  localparam int K_DROP  = 2;
  localparam int K_TMO   = 3;

  typedef struct {
    int         len;
    int         delay;   // cycles after last word to raise fin; <0 = never
    logic [7:0] proto;
    bit         ok;
    bit         spur;    // also raise fin during streaming (must be ignored)
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        src0_req, src1_req, src0_rd, src1_rd;
  logic [15:0] src0_len, src1_len;
  logic [31:0] src0_data, src1_data;
  logic        dec_reset, dec_start;
  logic [31:0] dec_data;
  logic [7:0]  dec_protocol = 8'd0;
  logic        dec_ok = 1'b0;
  logic        dec_fin = 1'b0;
  logic [1:0]  grant;
  logic        busy, udp_go, tcp_go, drop, timeout_err;
  logic [15:0] pkt_cnt, drop_cnt;

  ip_rx_arbiter dut (
    .clk(clk), .reset(reset),
    .src0_req(src0_req), .src0_len(src0_len), .src0_data(src0_data), .src0_rd(src0_rd),
    .src1_req(src1_req), .src1_len(src1_len), .src1_data(src1_data), .src1_rd(src1_rd),
    .dec_reset(dec_reset), .dec_start(dec_start), .dec_data(dec_data),
    .dec_protocol(dec_protocol), .dec_ok(dec_ok), .dec_fin(dec_fin),
    .grant(grant), .busy(busy), .udp_go(udp_go), .tcp_go(tcp_go), .drop(drop),
    .timeout_err(timeout_err), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- source FIFO models ----------------
  logic [31:0] words [2][4096];
  int plen [2][64];
  int pend [2][64];
  int nwr  [2] = '{0, 0};
  int npkt [2] = '{0, 0};
  int rdptr[2] = '{0, 0};
  int pidx [2] = '{0, 0};
  logic flush [2] = '{1'b0, 1'b0};
  logic [1:0] rd_v;

  assign rd_v      = {src1_rd, src0_rd};
  assign src0_req  = pidx[0] < npkt[0];
  assign src1_req  = pidx[1] < npkt[1];
  assign src0_len  = 16'(plen[0][pidx[0]]);
  assign src1_len  = 16'(plen[1][pidx[1]]);
  assign src0_data = words[0][rdptr[0]];
  assign src1_data = words[1][rdptr[1]];

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (flush[s]) begin
        if (pidx[s] < npkt[s]) begin
          rdptr[s] <= pend[s][pidx[s]];
          pidx[s]  <= pidx[s] + 1;
        end
      end else if (rd_v[s]) begin
        rdptr[s] <= rdptr[s] + 1;
        if (rdptr[s] + 1 == pend[s][pidx[s]]) pidx[s] <= pidx[s] + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  pkt_t        exp_pkt0[$], exp_pkt1[$];
  logic [31:0] exp_w0[$], exp_w1[$];
  int          exp_order[$];

  function automatic bit len_valid(input int len);
    return (len >= 7) && (len <= MAXW);
  endfunction

  function automatic int exp_kind(input pkt_t p);
    if (!len_valid(p.len)) return K_DROP;
    if (p.delay < 0 || p.delay >= FIN_TO) return K_TMO;
    if (p.ok && p.proto == 8'd17) return K_UDP;
    if (p.ok && p.proto == 8'd6) return K_TCP;
    return K_DROP;
  endfunction

  task automatic add_pkt(input int s, input int len, input int delay,
                         input logic [7:0] proto, input bit ok, input bit spur);
    pkt_t p;
    logic [31:0] w;
    p.len = len; p.delay = delay; p.proto = proto; p.ok = ok; p.spur = spur;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      words[s][nwr[s]] = w;
      nwr[s]++;
      if (len_valid(len)) begin
        if (s == 0) exp_w0.push_back(w); else exp_w1.push_back(w);
      end
    end
    plen[s][npkt[s]] = len;
    pend[s][npkt[s]] = nwr[s];
    if (s == 0) exp_pkt0.push_back(p); else exp_pkt1.push_back(p);
    npkt[s]++;
  endtask

  // ---------------- monitor + decoder responder ----------------
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          active = 0, after_done = 0, rd_prev = 0, valid = 0;
  int          owner, pops, nres, nstart, widx, last_t, kind;
  pkt_t        cur;
  logic [15:0] m_pkt_cnt = 16'd0, m_drop_cnt = 16'd0;
  logic [31:0] w_exp;

  always @(negedge clk) begin
    if (!reset) begin
      active = 0; after_done = 0; rd_prev = 0; dec_fin = 1'b0;
      m_pkt_cnt = 16'd0; m_drop_cnt = 16'd0;
    end else begin
      if (after_done) begin
        check("busy_after_done", 32'(busy), 32'd0);
        check("pulse_width", 32'({udp_go, tcp_go, drop, timeout_err}), 32'd0);
        after_done = 0;
      end else if (!active && (udp_go || tcp_go || drop || timeout_err)) begin
        check("spurious_pulse", 32'({udp_go, tcp_go, drop, timeout_err}), 32'd0);
      end
      if (!active && grant != 2'b00) begin
        active = 1;
        owner  = grant[1] ? 1 : 0;
        check("grant_onehot", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
        if (exp_order.size() > 0) check("grant_order", 32'(owner), 32'(exp_order.pop_front()));
        else check("grant_unexpected", 32'(grant), 32'd0);
        cur.len = -1; cur.delay = -1; cur.proto = 8'd0; cur.ok = 0; cur.spur = 0;
        if (owner == 0 && exp_pkt0.size() > 0) cur = exp_pkt0.pop_front();
        if (owner == 1 && exp_pkt1.size() > 0) cur = exp_pkt1.pop_front();
        valid = len_valid(cur.len);
        pops = 0; nres = 0; nstart = 0; widx = 0; last_t = -1; rd_prev = 0;
      end
      if (active) begin
        if (dec_reset) nres++;
        if (dec_start) nstart++;
        if (rd_prev && valid) begin
          w_exp = (owner == 0) ? exp_w0.pop_front() : exp_w1.pop_front();
          check("dec_data", dec_data, w_exp);
          check("dec_start", 32'(dec_start), 32'(widx < cur.len - 2));
          if (widx == cur.len - 1) last_t = cyc;
          widx++;
        end
        rd_prev = (owner == 0) ? src0_rd : src1_rd;
        if (rd_prev) pops++;
        if (((owner == 0) ? src1_rd : src0_rd) == 1'b1) check("rd_wrong_src", 32'(rd_v), 32'(1 << owner));
        dec_fin = 1'b0;
        if (valid && last_t >= 0 && cur.delay >= 0 && cyc == last_t + cur.delay) begin
          dec_fin = 1'b1; dec_ok = cur.ok; dec_protocol = cur.proto;
        end else if (valid && cur.spur && last_t < 0 && widx > 0) begin
          dec_fin = 1'b1; dec_ok = 1'b1; dec_protocol = 8'd17;
        end
        if (udp_go || tcp_go || drop) begin
          kind = exp_kind(cur);
          check("udp_go", 32'(udp_go), 32'(kind == K_UDP));
          check("tcp_go", 32'(tcp_go), 32'(kind == K_TCP));
          check("drop", 32'(drop), 32'(kind == K_DROP || kind == K_TMO));
          check("timeout_err", 32'(timeout_err), 32'(kind == K_TMO));
          if (valid) check("fin_latency", 32'(cyc - last_t), (kind == K_TMO) ? 32'(FIN_TO) : 32'(cur.delay + 1));
          check("pop_count", 32'(pops), 32'(cur.len));
          check("dec_reset_pulses", 32'(nres), valid ? 32'd1 : 32'd0);
          check("dec_start_count", 32'(nstart), valid ? 32'(cur.len - 2) : 32'd0);
          if (kind == K_UDP || kind == K_TCP) m_pkt_cnt++; else m_drop_cnt++;
          check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt_cnt));
          check("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
          check("grant_done", 32'(grant), 32'd0);
          check("busy_done", 32'(busy), 32'd1);
          dec_fin = 1'b0;
          active = 0; after_done = 1;
        end else begin
          check("grant_hold", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_pkt0.size() + exp_pkt1.size() > 0 || active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("wait_budget", 32'(exp_pkt0.size() + exp_pkt1.size() + 32'(active)), 32'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dec_reset"}, 32'(dec_reset), 32'd1);
    check({tag, "_dec_start"}, 32'(dec_start), 32'd0);
    check({tag, "_dec_data"}, dec_data, 32'd0);
    check({tag, "_rd"}, 32'(rd_v), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pulses"}, 32'({udp_go, tcp_go, drop, timeout_err}), 32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  logic [15:0] snap;
  int          n;

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_reset_dec_reset", 32'(dec_reset), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);

    // src0 UDP, len 8
    exp_order.push_back(0);
    add_pkt(0, 8, 2, 8'd17, 1'b1, 1'b0);
    wait_idle(300);
    check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // src1 TCP, fin 3 cycles after last word, stray fin while streaming
    @(negedge clk);
    exp_order.push_back(1);
    add_pkt(1, 10, 3, 8'd6, 1'b1, 1'b1);
    wait_idle(300);

    // Both sources contend
    @(negedge clk);
`ifdef IP_ARB_RR_EN
    exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(0);
`else
    exp_order.push_back(0); exp_order.push_back(0); exp_order.push_back(1);
`endif
    add_pkt(0, 8, 1, 8'd17, 1'b1, 1'b0);
    add_pkt(1, 8, 0, 8'd6, 1'b0, 1'b0);
    add_pkt(0, 8, 5, 8'd1, 1'b1, 1'b0);
    wait_idle(600);

    // fin never arrives, then a normal packet
    @(negedge clk);
    exp_order.push_back(0); exp_order.push_back(0);
    add_pkt(0, 9, -1, 8'd17, 1'b1, 1'b0);
    add_pkt(0, 7, 0, 8'd17, 1'b1, 1'b0);
    wait_idle(400);

    // Out-of-range lengths drain without touching the decoder
    @(negedge clk);
    snap = m_drop_cnt;
    exp_order.push_back(0); exp_order.push_back(0);
    add_pkt(0, 5, 0, 8'd17, 1'b1, 1'b0);
    add_pkt(0, 400, 0, 8'd17, 1'b1, 1'b0);
    wait_idle(1500);
    check("drain_drop_cnt", 32'(drop_cnt), 32'(16'(snap + 16'd2)));

    // Async reset during the 4th pop of an 8-word packet
    @(negedge clk);
    exp_order.push_back(0);
    add_pkt(0, 8, 1, 8'd17, 1'b1, 1'b0);
    n = 0;
    while (!(active && pops == 4) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reset_reach_pop4", 32'(pops), 32'd4);
    reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    flush[0] = 1'b1;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    exp_w0.delete();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("held_reset");
    @(negedge clk) reset = 1'b1;
    exp_order.push_back(1);
    add_pkt(1, 12, 4, 8'd17, 1'b1, 1'b0);
    wait_idle(300);
    check("after_reset_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("after_reset_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/ip_rx_arbiter.md
Name: ip_rx_arbiter

Overview:
- Sequences the single IP_decoder instance and shares it between two receive word sources (src0, src1), e.g. two MAC FIFOs.
- Selects a source, pulses the decoder reset, and streams the packet as 32-bit words with the decoder's start framing.
- Waits for fin/ok, then dispatches the decoded packet to the UDP or TCP path by protocol, or drops it.

Parameters:
- MAX_WORDS, 16'd375, largest accepted packet length in 32-bit words (1500 bytes).
- FIN_TIMEOUT, 16, cycles to wait for dec_fin after the last word before declaring a timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src0_req  in  1  level; src0 has a complete packet pending; held high until its last word is popped.
- src0_len  in  16  packet length in words; valid while src0_req.
- src0_data  in  32  show-ahead head word; valid while src0_req.
- src0_rd  out  1  pop; the next word appears on src0_data the following cycle.
- src1_req, src1_len, src1_data, src1_rd  same as src0.
- dec_reset  out  1  decoder reset, active-high, registered.
- dec_start  out  1  decoder start, registered.
- dec_data  out  32  decoder data word, registered.
- dec_protocol  in  8  decoder protocol field.
- dec_ok  in  1  decoder checksum/header OK.
- dec_fin  in  1  decoder finished.
- grant  out  2  one-hot owner; 00 when idle.
- busy  out  1  high in any state other than IDLE.
- udp_go  out  1  one-cycle pulse: packet accepted, protocol 17.
- tcp_go  out  1  one-cycle pulse: packet accepted, protocol 6.
- drop  out  1  one-cycle pulse: packet discarded.
- timeout_err  out  1  one-cycle pulse, coincident with drop, on fin timeout.
- pkt_cnt  out  16  accepted-packet counter, wraps.
- drop_cnt  out  16  dropped-packet counter, wraps.

Behaviour:
- Reset (reset=0, async): state IDLE; dec_reset=1; dec_start=0; dec_data=0; srcN_rd=0; grant=00; busy=0; all pulses 0; counters 0; RR pointer=src0.
- States: IDLE, CLR, STREAM, DRAIN, WAIT_FIN, DONE.
- IDLE → CLR:
  - Condition: any req and a valid length (7 ≤ len ≤ MAX_WORDS).
  - grant latches the winner; the decoder's source length is latched.
  - dec_reset=1 for exactly the CLR cycle, and 0 otherwise outside reset.
- IDLE → DRAIN: when the winner's len < 7 or len > MAX_WORDS.
- CLR → STREAM, next cycle.
- STREAM:
  - srcN_rd=1 every cycle for len cycles.
  - Registered one cycle later: dec_data <= srcN_data and dec_start=1 for word indices 0..len-3.
  - dec_start=0 for the last two words.
  - The word counter counts pops; after pop len-1 → WAIT_FIN.
- DRAIN: pops len words; the decoder is untouched (dec_start=0); then → DONE with drop.
- WAIT_FIN: the timer starts the cycle after the last dec_data word is presented.
  - dec_fin & dec_ok & protocol==17 → udp_go.
  - dec_fin & dec_ok & protocol==6 → tcp_go.
  - dec_fin & (!dec_ok | other protocol) → drop.
  - Timer reaching FIN_TIMEOUT without fin → drop + timeout_err.
  - If fin and timeout occur in the same cycle, fin wins.
- DONE: the pulse is asserted this cycle; pkt_cnt or drop_cnt increments; the RR pointer advances past the served source; grant=00; → IDLE.
- Arbitration:
  - Occurs only in IDLE.
  - Both req → the source selected by the RR pointer wins.
  - A single req → that source, regardless of pointer.
- A src_req falling mid-packet is ignored; popping continues for the latched len (source contract violation, no recovery).
- Minimum gap between packets: 1 IDLE cycle.
- dec_fin outside WAIT_FIN is ignored.
- Async reset mid-packet aborts immediately with no pulse and no count; the source must be flushed externally.

Optional Feature:
- Macro: IP_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, src0 always wins over src1; the RR pointer is not implemented; all other behaviour is identical.

Test Plan:
- src0 single packet, len=8 (5-word header, total_length=31, protocol=17, ok): 8 pops; dec_start high for 6 consecutive dec_data cycles then low for 2; dec_reset pulses once; udp_go after fin; pkt_cnt=1.
- src1 packet, protocol=6, dec_fin+dec_ok returned 3 cycles after the last word: tcp_go single pulse; grant=10 during the packet; busy drops to 0 the cycle after DONE.
- src0 and src1 both req with len=8 each, back-to-back (IP_ARB_RR_EN defined): order src0, src1, src0; with the macro undefined and src0 req held continuously, src1 is never granted.
- dec_fin never asserted: timeout_err and drop coincide exactly FIN_TIMEOUT=16 cycles after the last word; drop_cnt=1; the next packet is accepted normally.
- src0 len=5 and len=400: each drains 5/400 pops with dec_start never high and no dec_reset pulse, then a drop pulse; drop_cnt=2.
- reset asserted low at the 4th pop of an 8-word packet: all outputs return to reset values asynchronously; no pulse; counters 0.
